// File: rtl/irq_source_cond_pkg.sv
// irq_source_cond_pkg: register addresses and limits shared by the interrupt source conditioner.
package irq_source_cond_pkg;
   localparam int NUM_SRC_MAX = 32;
   localparam logic [2:0] ADDR_MODE   = 3'd0;
   localparam logic [2:0] ADDR_POL    = 3'd1;
   localparam logic [2:0] ADDR_PEND   = 3'd2;
   localparam logic [2:0] ADDR_RAW    = 3'd3;
   localparam logic [2:0] ADDR_SWSET  = 3'd4;
   localparam logic [2:0] ADDR_ENABLE = 3'd5;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: single-bit multi-flop synchroniser into PCLK with async reset to 0.
module irq_sync #(
   parameter int STAGES = 2
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;
   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) sync_q <= '0;
      else          sync_q <= {sync_q[STAGES-2:0], d_i};
   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/irq_source_cond.sv
// irq_source_cond: APB-programmable per-source edge/level interrupt conditioner
// feeding the active-high irqSource inputs of the interrupt controller.
module irq_source_cond
   import irq_source_cond_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic               PSEL,
   input  logic               PENABLE,
   input  logic               PWRITE,
   input  logic [4:2]         PADDR,
   input  logic [31:0]        PWDATA,
   output logic [31:0]        PRDATA,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic [NUM_SRC-1:0] irq_out
);
   logic [NUM_SRC-1:0] sync, prev_q, evt, wd, set, clr, pend_view;
   logic [NUM_SRC-1:0] mode_q, mode_d, pol_q, pol_d, en_q, en_d, pend_q, pend_d;
   logic [31:0] prdata_q, prdata_d;
   logic wr, rd, unused_pwdata;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
      irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .PCLK   (PCLK),
         .PRESETn(PRESETn),
         .d_i    (irq_in[i]),
         .q_o    (sync[i])
      );
   end

   assign wr = PSEL & PWRITE & ~PENABLE;
   assign rd = PSEL & ~PWRITE & ~PENABLE;
   assign wd = PWDATA[NUM_SRC-1:0];
   assign unused_pwdata = ^PWDATA;
   // Edges come from raw sync/prev, so a POL change alone can never fire.
   assign evt = (pol_q & prev_q & ~sync) | (~pol_q & sync & ~prev_q);

   always_comb begin
      mode_d = (wr && PADDR == ADDR_MODE)   ? wd : mode_q;
      pol_d  = (wr && PADDR == ADDR_POL)    ? wd : pol_q;
      en_d   = (wr && PADDR == ADDR_ENABLE) ? wd : en_q;
      set    = evt | ((wr && PADDR == ADDR_SWSET) ? wd : '0);
      clr    = (wr && PADDR == ADDR_PEND) ? wd : '0;
      // Set beats clear; level sources and sources changing mode hold nothing latched.
      pend_d = mode_q & (set | (pend_q & ~clr)) & ~(mode_q ^ mode_d);
   end

   assign pend_view = (mode_q & pend_q) | (~mode_q & (sync ^ pol_q));
   assign irq_out   = en_q & pend_view;

   always_comb begin
      prdata_d = '0;
      if (rd)
         case (PADDR)
            ADDR_MODE:   prdata_d = 32'(mode_q);
            ADDR_POL:    prdata_d = 32'(pol_q);
            ADDR_PEND:   prdata_d = 32'(pend_view);
            ADDR_RAW:    prdata_d = 32'(sync);
            ADDR_ENABLE: prdata_d = 32'(en_q);
            default:     prdata_d = '0;
         endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) begin
         mode_q   <= '0;
         pol_q    <= '0;
         en_q     <= '0;
         pend_q   <= '0;
         prev_q   <= '0;
         prdata_q <= '0;
      end else begin
         mode_q   <= mode_d;
         pol_q    <= pol_d;
         en_q     <= en_d;
         pend_q   <= pend_d;
         prev_q   <= sync;
         prdata_q <= prdata_d;
      end

   assign PRDATA = prdata_q;
endmodule

// File: tb/tb_irq_source_cond.sv
// tb_irq_source_cond: register table plus latency/corner sequences, reads checked via a scoreboard queue.
module tb_irq_source_cond;
   import irq_source_cond_pkg::*;
   localparam int N  = 8;
   localparam int SS = 2;

   logic          PCLK = 1'b0, PRESETn = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [2:0]    PADDR = '0;
   logic [31:0]   PWDATA = '0;
   logic [31:0]   PRDATA;
   logic [N-1:0]  irq_in = '0;
   logic [N-1:0]  irq_out;

   irq_source_cond #(.NUM_SRC(N), .SYNC_STAGES(SS)) dut (
      .PCLK   (PCLK),
      .PRESETn(PRESETn),
      .PSEL   (PSEL),
      .PENABLE(PENABLE),
      .PWRITE (PWRITE),
      .PADDR  (PADDR),
      .PWDATA (PWDATA),
      .PRDATA (PRDATA),
      .irq_in (irq_in),
      .irq_out(irq_out)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   typedef struct {
      bit          wr;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [7:0]  irq;
      string       name;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [2:0] a, input logic [31:0] exp, input string name);
      exp_t e;
      sb.push_back('{name, exp});
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      if (sb.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         check(e.name, PRDATA, e.exp);
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      check({name, "_idle"}, PRDATA, 32'h0);
   endtask

   function automatic void add(input bit wr, input logic [2:0] a, input logic [31:0] d,
                               input logic [7:0] q, input string nm);
      tbl.push_back('{wr, a, d, q, nm});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      add(0, ADDR_MODE,   32'h0,        8'h00, "rst_mode");
      add(0, ADDR_POL,    32'h0,        8'h00, "rst_pol");
      add(0, ADDR_PEND,   32'h0,        8'h00, "rst_pend");
      add(0, ADDR_RAW,    32'h0,        8'h00, "rst_raw");
      add(0, ADDR_SWSET,  32'h0,        8'h00, "rst_swset");
      add(0, ADDR_ENABLE, 32'h0,        8'h00, "rst_en");
      add(0, 3'd6,        32'h0,        8'h00, "rst_r6");
      add(0, 3'd7,        32'h0,        8'h00, "rst_r7");
      add(1, ADDR_MODE,   32'hFFFFFF5A, 8'h00, "w_mode");
      add(0, ADDR_MODE,   32'h5A,       8'h00, "r_mode");
      add(1, ADDR_POL,    32'h0F,       8'h00, "w_pol");
      add(0, ADDR_POL,    32'h0F,       8'h00, "r_pol");
      add(0, ADDR_PEND,   32'h05,       8'h00, "r_pend_lvl");
      add(1, ADDR_ENABLE, 32'h3C,       8'h04, "w_en");
      add(0, ADDR_ENABLE, 32'h3C,       8'h04, "r_en");
      add(1, 3'd6,        32'hFF,       8'h04, "w_r6");
      add(0, 3'd6,        32'h0,        8'h04, "r_r6");
      add(0, ADDR_MODE,   32'h5A,       8'h04, "r_mode2");
      add(0, ADDR_POL,    32'h0F,       8'h04, "r_pol2");
      add(1, ADDR_SWSET,  32'hFF,       8'h1C, "w_swset");
      add(0, ADDR_PEND,   32'h5F,       8'h1C, "r_pend_sw");
      add(0, ADDR_SWSET,  32'h0,        8'h1C, "r_swset");
      add(1, ADDR_MODE,   32'h50,       8'h1C, "w_mode_lvl");
      add(1, ADDR_MODE,   32'h5A,       8'h14, "w_mode_edge");
      add(0, ADDR_PEND,   32'h55,       8'h14, "r_pend_mchg");
      add(1, ADDR_PEND,   32'h10,       8'h04, "w_pend_w1c");
      add(0, ADDR_PEND,   32'h45,       8'h04, "r_pend_w1c");
      add(1, ADDR_MODE,   32'h0,        8'h0C, "w_mode0");
      add(1, ADDR_POL,    32'h0,        8'h00, "w_pol0");
      add(1, ADDR_ENABLE, 32'h0,        8'h00, "w_en0");
      add(0, ADDR_PEND,   32'h0,        8'h00, "r_pend_clr");

      repeat (3) @(posedge PCLK);
      #1;
      check("rst_irq", 32'(irq_out), 32'h0);
      check("rst_prdata", PRDATA, 32'h0);
      PRESETn = 1'b1;
      idle(2);

      foreach (tbl[k]) begin
         if (tbl[k].wr) apb_write(tbl[k].addr, tbl[k].data);
         else           apb_read(tbl[k].addr, tbl[k].data, tbl[k].name);
         check({tbl[k].name, "_irq"}, 32'(irq_out), 32'(tbl[k].irq));
      end

      // Source 3 edge latency and W1C with the line still high
      apb_write(ADDR_MODE, 32'h08);
      apb_write(ADDR_ENABLE, 32'h08);
      irq_in[3] = 1'b1;
      idle(SS);
      check("a_edge_early", 32'(irq_out), 32'h0);
      idle(1);
      check("a_edge_set", 32'(irq_out), 32'h08);
      apb_read(ADDR_PEND, 32'h08, "a_pend");
      apb_write(ADDR_PEND, 32'h08);
      check("a_w1c_irq", 32'(irq_out), 32'h0);
      idle(4);
      check("a_no_retrig", 32'(irq_out), 32'h0);
      apb_read(ADDR_PEND, 32'h0, "a_pend_clr");

      // Source 0 level mode, active low
      irq_in = 8'h01;
      idle(4);
      apb_write(ADDR_MODE, 32'h0);
      apb_write(ADDR_ENABLE, 32'h01);
      apb_write(ADDR_POL, 32'h01);
      check("b_lvl_hi", 32'(irq_out), 32'h0);
      irq_in[0] = 1'b0;
      idle(SS - 1);
      check("b_lvl_early", 32'(irq_out), 32'h0);
      idle(1);
      check("b_lvl_on", 32'(irq_out), 32'h01);
      apb_write(ADDR_PEND, 32'h01);
      check("b_w1c_noeff", 32'(irq_out), 32'h01);
      apb_read(ADDR_PEND, 32'h01, "b_pend");
      irq_in[0] = 1'b1;
      idle(SS);
      check("b_lvl_off", 32'(irq_out), 32'h0);

      // Source 5: edge event and W1C land on the same PCLK edge
      apb_write(ADDR_MODE, 32'h20);
      apb_write(ADDR_ENABLE, 32'h20);
      irq_in[5] = 1'b1;
      idle(SS);
      apb_write(ADDR_PEND, 32'h20);
      check("c_irq", 32'(irq_out), 32'h20);
      apb_read(ADDR_PEND, 32'h20, "c_pend_set_wins");
      apb_write(ADDR_PEND, 32'h20);
      apb_read(ADDR_PEND, 32'h0, "c_pend_clr");

      // Source 2 held high: POL toggles must not fire; SWSET latches while disabled
      irq_in = 8'h04;
      idle(4);
      apb_write(ADDR_ENABLE, 32'h0);
      apb_write(ADDR_POL, 32'h0);
      apb_write(ADDR_MODE, 32'h04);
      apb_read(ADDR_RAW, 32'h04, "d_raw");
      apb_write(ADDR_POL, 32'h04);
      apb_write(ADDR_POL, 32'h0);
      apb_read(ADDR_PEND, 32'h0, "d_pend_pol");
      apb_write(ADDR_SWSET, 32'h04);
      apb_read(ADDR_PEND, 32'h04, "d_pend_sw");
      check("d_irq_dis", 32'(irq_out), 32'h0);
      apb_write(ADDR_ENABLE, 32'h04);
      check("d_irq_en", 32'(irq_out), 32'h04);

      // Asynchronous reset in the middle of a read access
      irq_in = 8'h00;
      idle(4);
      apb_write(ADDR_MODE, 32'hFF);
      apb_write(ADDR_SWSET, 32'hFF);
      apb_write(ADDR_ENABLE, 32'hFF);
      check("e_irq_all", 32'(irq_out), 32'hFF);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = ADDR_PEND;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      check("e_prdata", PRDATA, 32'hFF);
      PRESETn = 1'b0;
      #1;
      check("e_rst_irq", 32'(irq_out), 32'h0);
      check("e_rst_prdata", PRDATA, 32'h0);
      PSEL = 1'b0; PENABLE = 1'b0;
      idle(2);
      PRESETn = 1'b1;
      idle(1);
      apb_read(ADDR_PEND, 32'h0, "e_pend");
      apb_read(ADDR_MODE, 32'h0, "e_mode");
      apb_read(ADDR_ENABLE, 32'h0, "e_en");
      check("e_irq_after", 32'(irq_out), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/irq_source_cond.md
# irq_source_cond

Per-source interrupt conditioner on the APB bus that sits directly upstream of the interrupt controller. It synchronises asynchronous external interrupt lines into PCLK. Each source is made edge- or level-sensitive with software-selected polarity. Edge events are latched in a pending register with write-1-to-clear. The conditioned, enabled lines drive the controller's active-high irqSource inputs.

## Interface
- NUM_SRC, 8: number of sources, 1..32
- SYNC_STAGES, 2: synchroniser depth, 2..4
- PCLK  in  1  APB clock; all logic in this domain
- PRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB write
- PADDR  in  [4:2]  register word address
- PWDATA  in  32  write data; bits above NUM_SRC-1 ignored
- PRDATA  out  32  registered read data; bits above NUM_SRC-1 read 0
- irq_in  in  NUM_SRC  raw external interrupt lines, asynchronous
- irq_out  out  NUM_SRC  conditioned active-high lines to the interrupt controller

## Operation
- Register map (PADDR[4:2]):
  - 0 MODE RW: 1 = edge, 0 = level
  - 1 POL RW: 0 = rising / high, 1 = falling / low
  - 2 PEND: read; write-1-to-clear
  - 3 RAW RO: synchronised input
  - 4 SWSET: write-1-to-set PEND; reads 0
  - 5 ENABLE RW
  - 6–7: reads 0; writes ignored
- Write strobe is PSEL & PWRITE & !PENABLE, i.e. the setup phase. The register updates on that PCLK edge.
- Read: during the setup phase (PSEL & !PWRITE & !PENABLE), the selected value is registered into PRDATA. PRDATA is valid throughout the access phase. At every other edge PRDATA is loaded with 0.
- Synchroniser: a SYNC_STAGES-deep flop chain per bit produces sync. A history register prev captures sync every cycle, regardless of mode.
- Edge detect: evt = POL ? (prev & ~sync) : (sync & ~prev). It is computed from raw sync, so changing POL never creates an event.
- Edge-mode PEND bit:
  - Sets on evt, or on a SWSET write of 1.
  - Clears on a PEND write of 1.
  - If a set and a clear occur in the same cycle, set wins.
- Level-mode PEND bit: reads the current qualified level, sync ^ POL. PEND W1C and SWSET writes have no effect.
- MODE write: any source whose mode changes has its latched pend flop cleared.
- Output: irq_out = ENABLE & (MODE ? pend_q : (sync ^ POL)). ENABLE masks the output only; edge pending still latches while the source is disabled.

## Timing
- Reset values:
  - MODE, POL, PEND, ENABLE, sync chain, prev: 0
  - PRDATA: 0
  - irq_out: 0
- Latency from an irq_in transition (first sampled at edge k):
  - sync changes at edge k+SYNC_STAGES-1.
  - Level mode: irq_out follows combinationally after that edge.
  - Edge mode: pend_q, and hence irq_out, is set at edge k+SYNC_STAGES.
- W1C or SWSET written in setup phase at edge n: PEND and irq_out change after edge n.
- A pulse shorter than one PCLK period may be missed. A pulse of at least 2 periods is guaranteed to be captured.
- Repeated edges while PEND is already set merge into a single pending event; there is no counter.
- Asynchronous PRESETn mid-operation clears all state immediately. The first edge after release is evaluated against prev = 0.

## Structure
- Package irq_source_cond_pkg holds:
  - the address constants ADDR_MODE..ADDR_ENABLE as 3-bit localparams
  - the NUM_SRC max (32)
- Sub-module irq_sync: a single-bit SYNC_STAGES synchroniser with async reset to 0, instantiated NUM_SRC times via generate.
- Top level holds the APB decode, the registers, the edge detect and the read mux.

## Test plan
- Reset then read all registers: every read returns 0, irq_out = 0.
- Source 3: MODE=1, POL=0, ENABLE=1. Drive irq_in[3] 0→1 → irq_out[3]=1 and PEND=0x08 after SYNC_STAGES+1 edges. Write PEND=0x08 → irq_out[3]=0 while irq_in stays high (no re-trigger).
- Source 0: level mode, POL=1, ENABLE=1. irq_in[0]=0 → irq_out[0]=1 after SYNC_STAGES edges. Write PEND=0x01 → no change. irq_in[0]=1 → irq_out[0]=0.
- Simultaneous edge and W1C on the same cycle for source 5 (edge mode) → PEND[5] remains 1.
- irq_in[2] held high, edge mode; toggle POL[2] 0→1→0 → PEND stays 0. SWSET=0x04 → PEND=0x04, irq_out[2]=1 only once ENABLE[2]=1.
- PRESETn asserted while PEND=0xFF and ENABLE=0xFF → irq_out=0 and PRDATA=0 immediately. After release, reads of PEND return 0.
